// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Read-side bus between the UART receive FIFO and the memory-mapped
//   peripheral logic that consumes received words.
//
//   Signals:
//     rd_en       pop the head word (ignored when empty)
//     err_clr     clear all sticky error flags
//     rd_data     head word of the FIFO, valid while rd_valid=1
//     rd_valid    FIFO not empty
//     full        FIFO holds FIFO_DEPTH words
//     fifo_count  number of words stored
//     frame_err   sticky: a stop bit was sampled low
//     overrun_err sticky: a word was dropped because the FIFO was full
//     parity_err  sticky: a parity mismatch was detected
//
//   Modports:
//     master  peripheral side (drives rd_en / err_clr)
//     slave   receiver side (drives data, status and flags)
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 rd_en;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 parity_err;

  modport master (
    output rd_en, err_clr,
    input  rd_data, rd_valid, full, fifo_count,
    input  frame_err, overrun_err, parity_err
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, rd_valid, full, fifo_count,
    output frame_err, overrun_err, parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Oversampling UART receiver (5..9 data bits, 1 stop bit) feeding a
//   first-word-fall-through receive FIFO, with sticky framing / overrun /
//   parity error flags.
//
//   Compile-time option: define UART_RX_PARITY_EN to add one even-parity
//   bit after the data bits (PARITY state present, parity_err live).
//   Without it frames are DATA_BITS-N-1 and parity_err is tied to 0.
//
//   Ports:
//     clk      system clock, rising edge
//     reset    asynchronous, active-low reset
//     uart_rx  serial input, idle high, asynchronous to clk
//     bus      uart_rx_fifo_if.slave read/status bus
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rx,
  uart_rx_fifo_if.slave bus
);
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Receiver state
  logic                 rx_meta_reg, rx_s_reg;
  logic [1:0]           sync_vld_reg;
  logic                 armed_reg, armed_next;
  state_t               state_reg, state_next;
  logic [TICK_W-1:0]    tick_reg, tick_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_reg, par_bad_next;
`endif
  logic                 push_req, frame_set, parity_set;

  // FIFO state
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 rd_valid_reg, full_reg;
  logic                 frame_err_reg, overrun_err_reg, parity_err_reg;
  logic                 pop, wr_en, overrun_set;

`ifdef UART_RX_PARITY_EN
  assign par_bad = par_bad_reg;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    armed_next = armed_reg;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_reg;
`endif
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        bit_next  = '0;
        // A start needs a real high sample first; this keeps a line held
        // low across reset (or after a frame) from looking like an edge.
        if (armed_reg && !rx_s_reg) begin
          state_next = START;
          armed_next = 1'b0;
        end else if (rx_s_reg && sync_vld_reg[1]) begin
          armed_next = 1'b1;
        end
      end
      START: begin
        if (tick_reg == HALF_LAST) begin
          tick_next  = '0;
          state_next = rx_s_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_reg == FULL_LAST) begin
          tick_next  = '0;
          shift_next = {rx_s_reg, shift_reg[DATA_BITS-1:1]};
          bit_next   = bit_reg + 4'd1;
          if (bit_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_reg == FULL_LAST) begin
          tick_next    = '0;
          par_bad_next = ^{shift_reg, rx_s_reg};
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_reg == FULL_LAST) begin
          state_next = IDLE;
          frame_set  = !rx_s_reg;
          parity_set = par_bad;
          push_req   = rx_s_reg && !par_bad;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop only counts when something is stored, so push+pop on an empty
  // FIFO degenerates to a plain push.
  assign pop         = bus.rd_en && rd_valid_reg;
  assign wr_en       = push_req && (!full_reg || pop);
  assign overrun_set = push_req && full_reg && !pop;

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (!wr_en && pop)
      count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg     <= 1'b1;
      rx_s_reg        <= 1'b1;
      sync_vld_reg    <= '0;
      armed_reg       <= 1'b0;
      state_reg       <= IDLE;
      tick_reg        <= '0;
      bit_reg         <= '0;
      shift_reg       <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg     <= 1'b0;
`endif
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rd_valid_reg    <= 1'b0;
      full_reg        <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
      parity_err_reg  <= 1'b0;
    end else begin
      rx_meta_reg     <= uart_rx;
      rx_s_reg        <= rx_meta_reg;
      // Marks when rx_s_reg holds a genuine line sample rather than its
      // reset value.
      sync_vld_reg    <= {sync_vld_reg[0], 1'b1};
      armed_reg       <= armed_next;
      state_reg       <= state_next;
      tick_reg        <= tick_next;
      bit_reg         <= bit_next;
      shift_reg       <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg     <= par_bad_next;
`endif
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg       <= count_next;
      rd_valid_reg    <= (count_next != '0);
      full_reg        <= (count_next == DEPTH);
      // New errors win over a simultaneous clear.
      frame_err_reg   <= frame_set   | (frame_err_reg   & ~bus.err_clr);
      overrun_err_reg <= overrun_set | (overrun_err_reg & ~bus.err_clr);
      parity_err_reg  <= parity_set  | (parity_err_reg  & ~bus.err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= shift_reg;
  end

  // Masked while empty so stale memory never shows after reset or drain.
  assign bus.rd_data     = rd_valid_reg ? mem[rd_ptr_reg] : '0;
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.full        = full_reg;
  assign bus.fifo_count  = count_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.overrun_err = overrun_err_reg;
  assign bus.parity_err  = parity_err_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int FD  = 4;

  logic clk;
  logic reset;
  logic uart_rx;

  uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .uart_rx(uart_rx),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge; returns at the end of the stop
  // bit with the line back high.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < DB; i++) begin
      uart_rx = d[i];
      idle(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = par_bit;
    idle(CPB);
`else
    if (par_bit === 1'bx) uart_rx = 1'b1;
`endif
    uart_rx = stop_bit;
    idle(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    sb.push_back(d);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic read_word(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed rd_valid=%0b", tag, bus.rd_valid);
    end else begin
      exp = sb.pop_front();
      check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
      check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    end
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_full"}, 32'(bus.full), 32'd0);
    check({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
    check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_overrun_err"}, 32'(bus.overrun_err), 32'd0);
    check({tag, "_parity_err"}, 32'(bus.parity_err), 32'd0);
  endtask

  initial begin
    logic [7:0] exp;
    reset = 1'b0;
    uart_rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
    idle(3);
    check_all_zero("reset");
    reset = 1'b1;
    idle(6);

    // Single frame with exact latency: visible 3+CPB/2+9*CPB cycles after the
    // falling edge, i.e. one cycle after send_frame returns.
    send_good(8'hA5);
    check("lat_before", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(bus.rd_valid), 32'd1);
    check("a5_count", 32'(bus.fifo_count), 32'd1);
    read_word("a5");
    check("a5_empty", 32'(bus.rd_valid), 32'd0);
    idle(4);

    // Fill, then overrun.
    for (int v = 1; v <= 4; v++) begin
      send_good(8'(v));
      idle(4);
    end
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.fifo_count), 32'd4);
    exp = 8'h05;
    send_frame(exp, 1'b1, ^exp);
    idle(4);
    check("ovr_flag", 32'(bus.overrun_err), 32'd1);
    check("ovr_count", 32'(bus.fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) read_word("ovr_rd");
    check("ovr_drained", 32'(bus.rd_valid), 32'd0);
    check("ovr_notfull", 32'(bus.full), 32'd0);
    pulse_clr();
    check("ovr_clr", 32'(bus.overrun_err), 32'd0);
    idle(4);

    // Push and pop in the same cycle while full.
    for (int v = 8'h21; v <= 8'h24; v++) begin
      send_good(8'(v));
      idle(4);
    end
    sb.push_back(8'h25);
    exp = 8'h25;
    send_frame(exp, 1'b1, ^exp);
    exp = sb.pop_front();
    check("pp_head", 32'(bus.rd_data), 32'(exp));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("pp_count", 32'(bus.fifo_count), 32'd4);
    check("pp_full", 32'(bus.full), 32'd1);
    check("pp_no_ovr", 32'(bus.overrun_err), 32'd0);
    for (int i = 0; i < 4; i++) read_word("pp_rd");
    check("pp_drained", 32'(bus.fifo_count), 32'd0);
    idle(4);

    // Framing error, then a good frame.
    exp = 8'h3C;
    send_frame(exp, 1'b0, ^exp);
    idle(4);
    check("fe_flag", 32'(bus.frame_err), 32'd1);
    check("fe_count", 32'(bus.fifo_count), 32'd0);
    send_good(8'h55);
    idle(4);
    read_word("fe_55");
    pulse_clr();
    check("fe_clr", 32'(bus.frame_err), 32'd0);
    idle(4);

    // One-cycle glitch on the line.
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    idle(30);
    check("gl_count", 32'(bus.fifo_count), 32'd0);
    check("gl_frame", 32'(bus.frame_err), 32'd0);
    check("gl_ovr", 32'(bus.overrun_err), 32'd0);
    check("gl_par", 32'(bus.parity_err), 32'd0);
    send_good(8'h5A);
    idle(4);
    read_word("gl_5a");
    idle(4);

    // Reset mid-frame with a stored word and a set flag.
    exp = 8'h3C;
    send_frame(exp, 1'b0, ^exp);
    idle(4);
    send_good(8'h11);
    idle(4);
    check("pre_rst_count", 32'(bus.fifo_count), 32'd1);
    check("pre_rst_fe", 32'(bus.frame_err), 32'd1);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b1;
      idle(CPB);
    end
    uart_rx = 1'b1;
    idle(2);
    reset = 1'b0;
    uart_rx = 1'b0;
    #1;
    check_all_zero("rst_mid");
    sb.delete();
    idle(3);
    reset = 1'b1;
    idle(12);
    uart_rx = 1'b1;
    idle(60);
    check("rst_low_count", 32'(bus.fifo_count), 32'd0);
    check("rst_low_fe", 32'(bus.frame_err), 32'd0);
    send_good(8'h81);
    idle(4);
    read_word("rst_81");
    idle(4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check("par_flag", 32'(bus.parity_err), 32'd1);
    check("par_count", 32'(bus.fifo_count), 32'd0);
    send_good(8'h07);
    idle(4);
    read_word("par_07");
    pulse_clr();
    check("par_clr", 32'(bus.parity_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish before 500000 time units");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO, replacing the fixed 8N1, single-byte-buffer receive path on the `uart_rx` pin of the RISC-V pipeline SoC. It oversamples the serial line with a programmable clocks-per-bit divisor and supports 5–9 data bits. Received words are buffered in a first-word-fall-through FIFO that the memory-mapped peripheral logic reads. Framing and overrun errors are reported as sticky flags; parity checking is an optional compile-time feature.

## Interface
- `CLKS_PER_BIT`, 434, system clocks per serial bit (≥4; 434 = 50 MHz / 115200).
- `DATA_BITS`, 8, data bits per frame, 5..9.
- `FIFO_DEPTH`, 16, FIFO entries, power of two ≥2.
- `clk` input 1: single system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `uart_rx` input 1: serial line, idle high, asynchronous to `clk`.
- `rd_en` input 1: pop the head word; ignored when empty.
- `err_clr` input 1: clear all sticky error flags.
- `rd_data` output DATA_BITS: head word of the FIFO, valid while `rd_valid`=1.
- `rd_valid` output 1: FIFO not empty.
- `full` output 1: FIFO holds FIFO_DEPTH words.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: number of words stored.
- `frame_err` output 1: sticky; a stop bit was sampled low.
- `overrun_err` output 1: sticky; a word was dropped because the FIFO was full.
- `parity_err` output 1: sticky; a parity mismatch was detected.

## Operation
- Reset values: all outputs 0; synchroniser flops 1; FSM in IDLE; FIFO pointers 0.
- Synchroniser: two flops feed `uart_rx` to a signal `rx_s`. The FSM sees only `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY exists only when parity is compiled in.
- IDLE: a falling edge on `rx_s` (previous 1, current 0) loads the bit counter. The FSM moves to START.
- START: waits CLKS_PER_BIT/2 cycles (integer division), then samples.
  - Sample = 0: move to DATA.
  - Sample = 1: the edge was a glitch; return to IDLE and store nothing.
- DATA: samples every CLKS_PER_BIT cycles, DATA_BITS times. Data is LSB first into the shift register.
- PARITY: one sample after CLKS_PER_BIT cycles. Parity is even: the XOR of the data and parity bits must be 0.
- STOP: one sample after CLKS_PER_BIT cycles.
  - Sample = 1 and parity OK: push the word.
  - Sample = 0: set `frame_err`, discard the word.
  - Parity bad: set `parity_err`, discard the word.
  - In every case, return to IDLE. Re-arming requires `rx_s` to go high and then fall again.
- FIFO behaviour:
  - First-word-fall-through: `rd_data` always shows the head entry.
  - A pop with `rd_en` while empty has no effect.
  - A push while full with no pop in the same cycle drops the word and sets `overrun_err`; FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, `fifo_count` is unchanged, no overrun.
  - Push and pop in the same cycle while empty: the push happens, the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` is a separate counter and saturates correctly at FIFO_DEPTH.
- Sticky flags:
  - `err_clr` clears all three flags.
  - If a new error and `err_clr` occur in the same cycle, the set wins.
- `reset` asserted mid-frame: asynchronously returns the FSM to IDLE, empties the FIFO and clears all flags. The partial frame is lost. After release, a line that is still low does not start a frame until it returns high.

## Timing
- Synchroniser latency: 2 cycles.
- Sample points fall at mid-bit: CLKS_PER_BIT/2 after the detected edge, then every CLKS_PER_BIT.
- The pushed word is visible on `rd_data`/`rd_valid` the cycle after the stop-bit sample.
  - Latency from the `uart_rx` falling edge is 3 + CLKS_PER_BIT/2 + (DATA_BITS+1+P)·CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- `rd_en` at cycle n: the next word appears on `rd_data`, and `fifo_count` decrements, at cycle n+1.
- Error flags assert one cycle after the offending sample.
- All outputs are registered, except `rd_data`, which is read combinationally from the FIFO memory at the registered read pointer.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame includes one even-parity bit after the data bits.
  - The PARITY state is present.
  - `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - Frames are DATA_BITS-N-1.
  - The PARITY state and its logic are removed.
  - `parity_err` is tied to 0.

## Test plan
All tests use CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4.
- Send frame 0xA5 → `rd_valid`=1 and `rd_data`=0xA5 at the computed latency. `fifo_count`=1. Pulse `rd_en` → `rd_valid`=0.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 without reading:
  - `full`=1 after 0x04.
  - `overrun_err`=1 after 0x05.
  - Four reads return 0x01–0x04 in order.
  - `err_clr` → `overrun_err`=0.
- Send 0x3C with the stop bit driven low → `frame_err`=1, `fifo_count` stays 0. The next valid 0x55 is received correctly.
- Pulse `uart_rx` low for 1 cycle → no word, FSM back in IDLE, no flags set.
- Assert `reset` during bit 3 of 0xFF → all outputs are 0 immediately. The following 0x81 is received correctly.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err`=1, no push. Send 0x07 with parity bit 1 → `rd_data`=0x07.
